tm1638_led_ctrl: RTL and testbench
==================================

Name: tm1638_led_ctrl

Overview:
Serial write controller for the TM1638 LED/key board. It transfers an 8-bit LED pattern, as produced by the LED effect generators, to the board's 8 discrete LEDs over the STB/CLK/DIO interface, then sets brightness and display on/off. It sits between the pattern generator and the board pins and sequences the full three-frame TM1638 write transaction on request.

Parameters:
CLK_DIV, 4, clki cycles per tm_clk half-period (≥1)
STB_GAP, 4, clki cycles tm_stb held high between frames (≥1)

Ports:
clki  input  1  system clock; all logic on rising edge
rs  input  1  synchronous reset, active-high
led_in  input  8  LED pattern; bit i drives LED i
bright  input  3  brightness level 0..7
disp_on  input  1  1 = display on
upd  input  1  update request; sampled in IDLE
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at transaction end
tm_stb  output  1  TM1638 STB, active-low
tm_clk  output  1  TM1638 CLK, idle high
tm_dio  output  1  TM1638 DIO (write-only drive)

Behaviour:
- Interface: one clock, clki. Reset rs is synchronous and active-high.
- Reset values: busy=0, done=0, tm_stb=1, tm_clk=1, tm_dio=1, FSM=IDLE, pending=0.
- Reset mid-transaction aborts the transaction; pins reach their idle levels on the next edge, and no done pulse is issued.
- Accept:
  - In IDLE, upd=1 or pending=1 starts a transaction.
  - On the accept edge, latch led_in/bright/disp_on into shadow registers and clear pending.
  - On the next cycle, busy=1 and tm_stb=0.
- Frames, each framed by tm_stb low:
  - F1: 0x40 (write data, auto-increment).
  - F2: 0xC0, then 16 data bytes for addresses 0..15.
    - Even address 2i: segment byte, 0x00.
    - Odd address 2i+1: {7'b0, led_sh[i]}.
  - F3: 0x80 | (disp_on_sh<<3) | bright_sh.
- Bytes are sent LSB first.
- States: IDLE, STB_SETUP, BIT_LO, BIT_HI, GAP, DONE.
- STB_SETUP: tm_stb=0, tm_clk=1 for CLK_DIV cycles.
- BIT_LO: tm_clk=0, tm_dio=current bit, for CLK_DIV cycles.
- BIT_HI: tm_clk=1, tm_dio held, for CLK_DIV cycles. The board samples on the rising edge.
- After BIT_HI:
  - Next bit, or next byte in the same frame, goes to BIT_LO.
  - The last bit of the frame goes to GAP.
- GAP: tm_stb=1, tm_clk=1, tm_dio=1 for STB_GAP cycles. Then STB_SETUP of the next frame, or DONE after F3.
- DONE: one cycle with done=1 and busy=0, then IDLE.
- Frame length: CLK_DIV + 16·CLK_DIV·nbytes + STB_GAP, with nbytes = 1, 17, 1.
- Total busy cycles: 3·CLK_DIV + 304·CLK_DIV + 3·STB_GAP.
- Inputs changing while busy do not affect the current transaction (shadow registers).
- upd=1 while busy sets pending. Multiple requests coalesce into one. A new transaction starts from IDLE on the cycle after DONE, using the values present at that accept.
- upd held high continuously gives back-to-back transactions, each separated by DONE plus one IDLE cycle.
- Counters:
  - Divider counter: ⌈log2(max(CLK_DIV,STB_GAP))⌉+1 bits, wraps to 0 at each phase change.
  - Bit index: 3 bits.
  - Byte index: 5 bits.

Optional Feature:
TM1638_SEG_EN:
- Defined: adds input seg_in [63:0]. Byte seg_in[8i+7:8i] is latched at accept and sent at address 2i, driving the 7-segment digit i.
- Undefined: no seg_in port; even addresses send 0x00. All timing is identical either way.

Test Plan:
- Reset: assert rs mid-F2 (CLK_DIV=2, STB_GAP=2) -> next edge tm_stb=1, tm_clk=1, tm_dio=1, busy=0; no done pulse; a following upd runs a full transaction.
- Basic write: led_in=8'hA5, bright=7, disp_on=1, upd pulse -> decoded bytes are:
  - F1: 0x40.
  - F2: C0,00,01,00,00,00,01,00,00,00,00,00,01,00,00,00,01.
  - F3: 0x8F.
  - busy high exactly 620 cycles, done 1 cycle.
- Display off: disp_on=0, bright=3 -> F3 byte 0x83; F1/F2 unchanged format.
- Shadowing: change led_in from 8'h01 to 8'hFF during F2 -> all LED bytes reflect 8'h01.
- Pending: upd pulsed twice during busy -> exactly one extra transaction, starting 2 cycles after the first done, carrying the led_in present at its accept.
- Timing: CLK_DIV=1, STB_GAP=1 -> tm_clk alternates every cycle; every tm_dio change occurs only while tm_clk=0; tm_stb high exactly 1 cycle between frames.

Source files
------------

// File: rtl/tm1638_led_ctrl.sv
// TM1638 serial write controller: pushes an 8-LED pattern plus brightness/on state.
// Optional macro TM1638_SEG_EN adds seg_in for the 7-segment digits (even addresses).
module tm1638_led_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int STB_GAP = 4
) (
    input  logic        clki,
    input  logic        rs,
    input  logic [7:0]  led_in,
    input  logic [2:0]  bright,
    input  logic        disp_on,
    input  logic        upd,
`ifdef TM1638_SEG_EN
    input  logic [63:0] seg_in,
`endif
    output logic        busy,
    output logic        done,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio
);

    localparam int MAXC = (CLK_DIV > STB_GAP) ? CLK_DIV : STB_GAP;
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(STB_GAP - 1);
    localparam logic [4:0] F2_LAST = 5'd17;
    localparam logic [4:0] F3_BYTE = 5'd18;
    localparam logic [4:0] END_IDX = 5'd19;

    typedef enum logic [2:0] {
        IDLE,
        STB_SETUP,
        BIT_LO,
        BIT_HI,
        GAP,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]   bit_q, bit_d;
    logic [4:0]   byte_q, byte_d;
    logic         pend_q, pend_d;
    logic [7:0]   led_sh_q, led_sh_d;
    logic [2:0]   bright_sh_q, bright_sh_d;
    logic         disp_sh_q, disp_sh_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         stb_q, stb_d;
    logic         clk_q, clk_d;
    logic         dio_q, dio_d;
    logic [63:0]  seg_cur;
    logic [7:0]   cur_byte;

`ifdef TM1638_SEG_EN
    logic [63:0]  seg_sh_q, seg_sh_d;
    assign seg_cur = seg_sh_d;
`else
    assign seg_cur = 64'd0;
`endif

    // Global byte index: 0 = F1 cmd, 1 = F2 addr cmd, 2..17 = data, 18 = F3.
    function automatic logic [7:0] frame_byte(
        input logic [4:0]  idx,
        input logic [7:0]  led,
        input logic [63:0] seg,
        input logic        disp,
        input logic [2:0]  br
    );
        logic [3:0] addr;
        logic [7:0] b;
        addr = 4'(idx - 5'd2);
        b = 8'h00;
        if (idx == 5'd0) begin
            b = 8'h40;
        end else if (idx == 5'd1) begin
            b = 8'hC0;
        end else if (idx == F3_BYTE) begin
            b = {4'h8, disp, br};
        end else if (addr[0]) begin
            b = {7'b0, led[addr[3:1]]};
        end else begin
            b = seg[{addr[3:1], 3'b000} +: 8];
        end
        return b;
    endfunction

    function automatic logic frame_last(input logic [4:0] idx);
        return (idx == 5'd0) || (idx == F2_LAST) || (idx == F3_BYTE);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        pend_d      = pend_q;
        led_sh_d    = led_sh_q;
        bright_sh_d = bright_sh_q;
        disp_sh_d   = disp_sh_q;
`ifdef TM1638_SEG_EN
        seg_sh_d    = seg_sh_q;
`endif
        if (state_q != IDLE && upd) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (upd || pend_q) begin
                    state_d     = STB_SETUP;
                    cnt_d       = '0;
                    bit_d       = 3'd0;
                    byte_d      = 5'd0;
                    pend_d      = 1'b0;
                    led_sh_d    = led_in;
                    bright_sh_d = bright;
                    disp_sh_d   = disp_on;
`ifdef TM1638_SEG_EN
                    seg_sh_d    = seg_in;
`endif
                end
            end
            STB_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = BIT_LO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BIT_LO: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = BIT_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BIT_HI: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        byte_d  = byte_q + 5'd1;
                        state_d = frame_last(byte_q) ? GAP : BIT_LO;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = BIT_LO;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (byte_q == END_IDX) ? DONE : STB_SETUP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pins are decoded from the next state so they leave the flops glitch-free.
    always_comb begin
        stb_d    = 1'b1;
        clk_d    = 1'b1;
        dio_d    = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        cur_byte = frame_byte(byte_d, led_sh_d, seg_cur, disp_sh_d, bright_sh_d);
        unique case (state_d)
            STB_SETUP: begin
                stb_d  = 1'b0;
                busy_d = 1'b1;
            end
            BIT_LO: begin
                stb_d  = 1'b0;
                clk_d  = 1'b0;
                dio_d  = cur_byte[bit_d];
                busy_d = 1'b1;
            end
            BIT_HI: begin
                stb_d  = 1'b0;
                dio_d  = cur_byte[bit_d];
                busy_d = 1'b1;
            end
            GAP: begin
                busy_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clki) begin
        if (rs) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            byte_q      <= 5'd0;
            pend_q      <= 1'b0;
            led_sh_q    <= 8'd0;
            bright_sh_q <= 3'd0;
            disp_sh_q   <= 1'b0;
`ifdef TM1638_SEG_EN
            seg_sh_q    <= 64'd0;
`endif
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stb_q       <= 1'b1;
            clk_q       <= 1'b1;
            dio_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            pend_q      <= pend_d;
            led_sh_q    <= led_sh_d;
            bright_sh_q <= bright_sh_d;
            disp_sh_q   <= disp_sh_d;
`ifdef TM1638_SEG_EN
            seg_sh_q    <= seg_sh_d;
`endif
            busy_q      <= busy_d;
            done_q      <= done_d;
            stb_q       <= stb_d;
            clk_q       <= clk_d;
            dio_q       <= dio_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign tm_stb = stb_q;
    assign tm_clk = clk_q;
    assign tm_dio = dio_q;

endmodule

// File: tb/tb_tm1638_led_ctrl.sv
// Bench for tm1638_led_ctrl: decodes the serial bus back into frames and
// compares against byte lists built from the TM1638 write sequence.
module tb_tm1638_led_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rs;
    logic [7:0] led_in;
    logic [2:0] bright;
    logic       disp_on;
    logic       upd_drv;
    logic       sel;
    logic       upd0, upd1;
    logic       busy0, done0, stb0, tclk0, dio0;
    logic       busy1, done1, stb1, tclk1, dio1;
    logic       m_busy, m_done, m_stb, m_clk, m_dio;

    assign upd0 = upd_drv & ~sel;
    assign upd1 = upd_drv & sel;

    tm1638_led_ctrl #(.CLK_DIV(2), .STB_GAP(2)) dut (
        .clki(clk), .rs(rs), .led_in(led_in), .bright(bright),
        .disp_on(disp_on), .upd(upd0),
`ifdef TM1638_SEG_EN
        .seg_in(64'd0),
`endif
        .busy(busy0), .done(done0), .tm_stb(stb0), .tm_clk(tclk0), .tm_dio(dio0)
    );

    tm1638_led_ctrl #(.CLK_DIV(1), .STB_GAP(1)) dut_fast (
        .clki(clk), .rs(rs), .led_in(led_in), .bright(bright),
        .disp_on(disp_on), .upd(upd1),
`ifdef TM1638_SEG_EN
        .seg_in(64'd0),
`endif
        .busy(busy1), .done(done1), .tm_stb(stb1), .tm_clk(tclk1), .tm_dio(dio1)
    );

    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_stb  = sel ? stb1  : stb0;
    assign m_clk  = sel ? tclk1 : tclk0;
    assign m_dio  = sel ? dio1  : dio0;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] got[$];
    int frames[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Byte k of the 19-byte write sequence, straight from the command set.
    function automatic logic [7:0] model_byte(int k, logic [7:0] led, logic [2:0] br, logic dsp);
        int a;
        if (k == 0) return 8'h40;
        if (k == 1) return 8'hC0;
        if (k == 18) return 8'h80 + (dsp ? 8'd8 : 8'd0) + 8'(br);
        a = k - 2;
        if (a % 2 == 1) return led[a / 2] ? 8'd1 : 8'd0;
        return 8'h00;
    endfunction

    task automatic watch(input string tag, input bit start, input logic [7:0] led,
                         input logic [2:0] br, input logic dsp, input bit mid_chg,
                         input logic [7:0] mid_led, input bit mid_upd, output int lead);
        int cd, gp, cyc, busy_n, done_n, nbit, fbytes;
        int low_run, hi_run, gap_run, n_gaps, bad_run, bad_dio, bad_gap;
        bit seen_busy, fin, end_done;
        logic p_stb, p_clk, p_dio;
        logic [7:0] acc;
        cd = sel ? 1 : 2;
        gp = sel ? 1 : 2;
        got.delete();
        frames.delete();
        if (start) begin
            led_in = led;
            bright = br;
            disp_on = dsp;
            upd_drv = 1'b1;
        end
        cyc = 0; busy_n = 0; done_n = 0; nbit = 0; fbytes = 0; acc = 8'd0;
        low_run = 0; hi_run = 0; gap_run = 0; n_gaps = 0;
        bad_run = 0; bad_dio = 0; bad_gap = 0;
        seen_busy = 0; fin = 0; end_done = 0; lead = -1;
        p_stb = 1'b1; p_clk = 1'b1; p_dio = 1'b1;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            upd_drv = mid_upd && (busy_n == 150 || busy_n == 300);
            if (m_busy) begin
                busy_n++;
                if (!seen_busy) begin
                    seen_busy = 1;
                    lead = cyc;
                end
            end
            if (mid_chg && busy_n == 100) led_in = mid_led;
            if (m_done) done_n++;
            if (!m_stb) begin
                if (!p_clk && m_clk) begin
                    acc[nbit] = m_dio;
                    nbit++;
                    if (low_run != cd) bad_run++;
                    low_run = 0;
                    if (nbit == 8) begin
                        got.push_back(acc);
                        fbytes++;
                        nbit = 0;
                    end
                end
                if (p_clk && !m_clk && !p_stb) begin
                    if (hi_run != cd) bad_run++;
                    hi_run = 0;
                end
                if (m_clk) hi_run++;
                else low_run++;
                if (!p_stb && m_dio !== p_dio && m_clk) bad_dio++;
                if (p_stb && gap_run > 0) begin
                    if (gap_run != gp) bad_gap++;
                    n_gaps++;
                    gap_run = 0;
                end
            end else begin
                hi_run = 0;
                low_run = 0;
                if (m_busy) gap_run++;
                if (!p_stb) begin
                    frames.push_back(fbytes);
                    fbytes = 0;
                end
            end
            if (seen_busy && !m_busy) begin
                fin = 1;
                end_done = m_done;
                if (gap_run != gp) bad_gap++;
                n_gaps++;
            end
            p_stb = m_stb; p_clk = m_clk; p_dio = m_dio;
        end
        upd_drv = 1'b0;
        check({tag, " finished"}, 32'(fin), 32'd1);
        check({tag, " busy cycles"}, busy_n, 3 * cd + 304 * cd + 3 * gp);
        check({tag, " done at end"}, 32'(end_done), 32'd1);
        check({tag, " done count"}, done_n, 1);
        check({tag, " byte count"}, got.size(), 19);
        check({tag, " frame count"}, frames.size(), 3);
        if (frames.size() == 3) begin
            check({tag, " f1 len"}, frames[0], 1);
            check({tag, " f2 len"}, frames[1], 17);
            check({tag, " f3 len"}, frames[2], 1);
        end
        for (int k = 0; k < got.size() && k < 19; k++)
            check($sformatf("%s byte%0d", tag, k), got[k], model_byte(k, led, br, dsp));
        check({tag, " clk phase len"}, bad_run, 0);
        check({tag, " dio moved with clk high"}, bad_dio, 0);
        check({tag, " stb gap len"}, bad_gap, 0);
        check({tag, " gap count"}, n_gaps, 3);
    endtask

    task automatic idle(input string tag, input int n);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (m_busy || m_done) act++;
        end
        check({tag, " quiet"}, act, 0);
    endtask

    initial begin
        int lead, dn, bz;
        logic [7:0] rl;
        logic [2:0] rb;
        logic rd;
        sel = 1'b0; rs = 1'b1; upd_drv = 1'b0;
        led_in = 8'd0; bright = 3'd0; disp_on = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", busy0, 1'b0);
        check("rst done", done0, 1'b0);
        check("rst stb", stb0, 1'b1);
        check("rst clk", tclk0, 1'b1);
        check("rst dio", dio0, 1'b1);
        check("rst fast busy", busy1, 1'b0);
        rs = 1'b0;
        @(negedge clk);

        // abort mid-F2, then a clean transaction must still run
        led_in = 8'h3C; bright = 3'd4; disp_on = 1'b1; upd_drv = 1'b1;
        @(negedge clk);
        upd_drv = 1'b0;
        repeat (99) @(negedge clk);
        check("abort in flight", busy0, 1'b1);
        rs = 1'b1;
        @(negedge clk);
        rs = 1'b0;
        check("abort stb", stb0, 1'b1);
        check("abort clk", tclk0, 1'b1);
        check("abort dio", dio0, 1'b1);
        check("abort busy", busy0, 1'b0);
        dn = 0; bz = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (done0) dn++;
            if (busy0) bz++;
        end
        check("abort no done", dn, 0);
        check("abort no restart", bz, 0);
        watch("after_rst", 1, 8'h96, 3'd1, 1'b1, 0, 8'd0, 0, lead);
        idle("after_rst", 4);

        watch("basic", 1, 8'hA5, 3'd7, 1'b1, 0, 8'd0, 0, lead);
        check("basic lead", lead, 1);
        if (got.size() == 19) check("basic f3 byte", got[18], 8'h8F);
        idle("basic", 4);

        watch("dispoff", 1, 8'h5C, 3'd3, 1'b0, 0, 8'd0, 0, lead);
        if (got.size() == 19) check("dispoff f3 byte", got[18], 8'h83);
        idle("dispoff", 4);

        watch("shadow", 1, 8'h01, 3'd5, 1'b1, 1, 8'hFF, 0, lead);
        idle("shadow", 4);

        watch("pend1", 1, 8'h5A, 3'd2, 1'b1, 1, 8'hC3, 1, lead);
        watch("pend2", 0, 8'hC3, 3'd2, 1'b1, 0, 8'd0, 0, lead);
        check("pend2 lead", lead, 2);
        idle("no third", 30);

        for (int i = 0; i < 4; i++) begin
            rl = 8'($urandom);
            rb = 3'($urandom_range(0, 7));
            rd = 1'($urandom_range(0, 1));
            watch($sformatf("rnd%0d", i), 1, rl, rb, rd, 0, 8'd0, 0, lead);
            idle($sformatf("rnd%0d", i), 2 + $urandom_range(0, 5));
        end

        sel = 1'b1;
        @(negedge clk);
        watch("fast", 1, 8'hA5, 3'd7, 1'b1, 0, 8'd0, 0, lead);
        check("fast lead", lead, 1);
        idle("fast", 3);
        for (int i = 0; i < 3; i++) begin
            rl = 8'($urandom);
            rb = 3'($urandom_range(0, 7));
            rd = 1'($urandom_range(0, 1));
            watch($sformatf("frnd%0d", i), 1, rl, rb, rd, 0, 8'd0, 0, lead);
            idle($sformatf("frnd%0d", i), 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
